// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width and ALUOp encodings used by the control unit and the ALU.
package alu_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

endpackage

// File: rtl/alu_addsub.sv
// Adder/subtractor with two's-complement overflow detection; subtract is a + ~b + 1.
module alu_addsub
  import alu_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              sub_i,
  output logic [DATA_W-1:0] sum_o,
  output logic              ovf_o
);

  logic [DATA_W-1:0] b_eff;
  logic [DATA_W:0]   sum_full;

  always_comb begin
    b_eff    = sub_i ? ~b_i : b_i;
    sum_full = {1'b0, a_i} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub_i};
    sum_o    = sum_full[DATA_W-1:0];
    // Using the inverted b sign covers both ADD and SUB overflow rules with one compare.
    ovf_o    = (a_i[DATA_W-1] == b_eff[DATA_W-1]) && (sum_o[DATA_W-1] != a_i[DATA_W-1]);
  end

endmodule

// File: rtl/alu.sv
// 32-bit ALU (ADD/SUB/AND/OR) with combinational result/Zero/Overflow and registered copies.
module alu
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] num_1,
  input  logic [DATA_W-1:0] num_2,
  input  logic [1:0]        ALUOp,
  output logic [DATA_W-1:0] result,
  output logic              Zero,
  output logic              Overflow,
  output logic [DATA_W-1:0] result_q,
  output logic              zero_q,
  output logic              ovf_q
);

  alu_op_e           op;
  logic [DATA_W-1:0] as_sum;
  logic              as_ovf;
  logic [DATA_W-1:0] result_d;
  logic              zero_d;
  logic              ovf_d;

  assign op = alu_op_e'(ALUOp);

  alu_addsub u_addsub (
    .a_i   (num_1),
    .b_i   (num_2),
    .sub_i (op == ALU_SUB),
    .sum_o (as_sum),
    .ovf_o (as_ovf)
  );

  always_comb begin
    result_d = '0;
    ovf_d    = 1'b0;
    unique case (op)
      ALU_ADD: begin result_d = as_sum;        ovf_d = as_ovf; end
      ALU_SUB: begin result_d = as_sum;        ovf_d = as_ovf; end
      ALU_AND: begin result_d = num_1 & num_2; ovf_d = 1'b0;   end
      ALU_OR:  begin result_d = num_1 | num_2; ovf_d = 1'b0;   end
      default: begin result_d = '0;            ovf_d = 1'b0;   end
    endcase
    zero_d = ~|result_d;
  end

  assign result   = result_d;
  assign Zero     = zero_d;
  assign Overflow = ovf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      zero_q   <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed vectors with literal expectations plus a per-cycle model compare.
module tb_alu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] num_1 = '0;
  logic [31:0] num_2 = '0;
  logic [1:0]  ALUOp = 2'b00;
  logic [31:0] result, result_q;
  logic        Zero, Overflow, zero_q, ovf_q;

  int unsigned errors = 0;
  int unsigned checks = 0;
  bit          cmp_en = 1'b0;

  logic [31:0] exp_rq = '0;
  logic        exp_zq = 1'b1;
  logic        exp_oq = 1'b0;

  alu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .num_1    (num_1),
    .num_2    (num_2),
    .ALUOp    (ALUOp),
    .result   (result),
    .Zero     (Zero),
    .Overflow (Overflow),
    .result_q (result_q),
    .zero_q   (zero_q),
    .ovf_q    (ovf_q)
  );

  always #5 clk = ~clk;

  // Signed arithmetic in 64 bits: overflow is simply "true sum out of 32-bit signed range".
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                                output logic [31:0] r, output logic z, output logic o);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0;
    o = 1'b0;
    case (op)
      2'd0: begin s = sa + sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      2'd1: begin s = sa - sb; r = s[31:0]; o = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      2'd2: r = a & b;
      default: r = a | b;
    endcase
    z = (r == 32'h0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    logic [31:0] r;
    logic z, o;
    if (!rst_n) begin
      exp_rq <= '0;
      exp_zq <= 1'b1;
      exp_oq <= 1'b0;
    end else begin
      model(num_1, num_2, ALUOp, r, z, o);
      exp_rq <= r;
      exp_zq <= z;
      exp_oq <= o;
    end
  end

  always @(negedge clk) begin
    logic [31:0] r;
    logic z, o;
    if (cmp_en) begin
      model(num_1, num_2, ALUOp, r, z, o);
      chk("cyc_result",   result,   r);
      chk("cyc_zero",     {31'b0, Zero},     {31'b0, z});
      chk("cyc_overflow", {31'b0, Overflow}, {31'b0, o});
      chk("cyc_result_q", result_q, exp_rq);
      chk("cyc_zero_q",   {31'b0, zero_q},   {31'b0, exp_zq});
      chk("cyc_ovf_q",    {31'b0, ovf_q},    {31'b0, exp_oq});
    end
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] r;
    logic        z;
    logic        o;
  } vec_t;

  vec_t vecs[$];

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    num_1 = a;
    num_2 = b;
    ALUOp = op;
  endtask

  initial begin
    logic [31:0] mr;
    logic mz, mo;

    vecs.push_back('{32'h00000000, 32'h00000000, 2'b00, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 2'b00, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{32'h7FFFFFFF, 32'h00000001, 2'b00, 32'h80000000, 1'b0, 1'b1});
    vecs.push_back('{32'h80000000, 32'h80000000, 2'b00, 32'h00000000, 1'b1, 1'b1});
    vecs.push_back('{32'h00000005, 32'h00000005, 2'b01, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{32'h80000000, 32'h00000001, 2'b01, 32'h7FFFFFFF, 1'b0, 1'b1});
    vecs.push_back('{32'h7FFFFFFF, 32'hFFFFFFFF, 2'b01, 32'h80000000, 1'b0, 1'b1});
    vecs.push_back('{32'h00000003, 32'h00000005, 2'b01, 32'hFFFFFFFE, 1'b0, 1'b0});
    vecs.push_back('{32'hF0F0F0F0, 32'h0FF00FF0, 2'b10, 32'h00F000F0, 1'b0, 1'b0});
    vecs.push_back('{32'hF0F0F0F0, 32'h0FF00FF0, 2'b11, 32'hFFF0FFF0, 1'b0, 1'b0});
    vecs.push_back('{32'hF0F0F0F0, 32'h0F0F0F0F, 2'b10, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{32'h7FFFFFFF, 32'h00000001, 2'b11, 32'h7FFFFFFF, 1'b0, 1'b0});
    vecs.push_back('{32'h00000000, 32'h00000000, 2'b11, 32'h00000000, 1'b1, 1'b0});

    #1 rst_n = 1'b0;
    #2;
    chk("rst_result_q", result_q, 32'h0);
    chk("rst_zero_q",   {31'b0, zero_q}, 32'h1);
    chk("rst_ovf_q",    {31'b0, ovf_q},  32'h0);
    drive(32'h7FFFFFFF, 32'h00000001, 2'b00);
    #1;
    chk("rst_comb_result", result, 32'h80000000);
    chk("rst_comb_ovf",    {31'b0, Overflow}, 32'h1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;

    foreach (vecs[i]) begin
      @(posedge clk);
      #2 drive(vecs[i].a, vecs[i].b, vecs[i].op);
      #1;
      model(vecs[i].a, vecs[i].b, vecs[i].op, mr, mz, mo);
      chk($sformatf("model_r%0d", i), mr, vecs[i].r);
      chk($sformatf("model_o%0d", i), {31'b0, mo}, {31'b0, vecs[i].o});
      chk($sformatf("vec_result%0d", i),   result,            vecs[i].r);
      chk($sformatf("vec_zero%0d", i),     {31'b0, Zero},     {31'b0, vecs[i].z});
      chk($sformatf("vec_overflow%0d", i), {31'b0, Overflow}, {31'b0, vecs[i].o});
      @(posedge clk);
      #1;
      chk($sformatf("vec_result_q%0d", i), result_q,        vecs[i].r);
      chk($sformatf("vec_zero_q%0d", i),   {31'b0, zero_q}, {31'b0, vecs[i].z});
      chk($sformatf("vec_ovf_q%0d", i),    {31'b0, ovf_q},  {31'b0, vecs[i].o});
    end

    // Registered load then asynchronous reset between edges.
    @(posedge clk);
    #2 drive(32'h7FFFFFFF, 32'h00000001, 2'b00);
    @(posedge clk);
    #1;
    chk("ld_result_q", result_q, 32'h80000000);
    chk("ld_ovf_q",    {31'b0, ovf_q}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_result_q", result_q, 32'h0);
    chk("async_zero_q",   {31'b0, zero_q}, 32'h1);
    chk("async_ovf_q",    {31'b0, ovf_q},  32'h0);
    chk("async_result",   result, 32'h80000000);
    @(posedge clk);
    #1;
    chk("hold_result_q", result_q, 32'h0);
    #1 rst_n = 1'b1;
    drive(32'hF0F0F0F0, 32'h0FF00FF0, 2'b10);
    @(posedge clk);
    #1;
    chk("post_rst_result_q", result_q, 32'h00F000F0);
    chk("post_rst_zero_q",   {31'b0, zero_q}, 32'h0);
    @(posedge clk);
    #1;
    cmp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
